pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning EX-stage latency in cycles of a multiply; legal range 2..63.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning EX-stage latency in cycles of a divide; legal range 2..63.
REQ-003 clk  input  1  single clock; all state updates on falling edge, same edge as the pipeline registers.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_rs_re, id_rt_re  input  1 each  ID instruction reads rs / rt.
REQ-007 ex_is_load  input  1  EX instruction is a load.
REQ-008 ex_rd  input  5  EX destination register.
REQ-009 ex_md_start, ex_md_is_div  input  1 each  EX holds mult/div; 1 = divide, 0 = multiply.
REQ-010 branch_taken  input  1  taken branch/jump resolved in ID.
REQ-011 exc_flush  input  1  exception/eret redirect.
REQ-012 pc_wena, ifid_wena, idex_wena, exmem_wena, memwb_wena  output  1 each  pipeline register write enables.
REQ-013 ifid_flush, idex_bubble, exmem_bubble  output  1 each  load NOP into IF/ID, ID/EX, EX/MEM.
REQ-014 md_busy, md_done  output  1 each  mult/div stall in progress; one-cycle release pulse.
REQ-015 stall_cnt  output  32  count of stall cycles.

Function
REQ-016 States SHALL be RUN and MD_WAIT, with a 6-bit down-counter cnt.
REQ-017 Enables, flush and bubble outputs SHALL be combinational from state, cnt and inputs.
REQ-018 Default in RUN (no event): all five enables 1; flush, bubble and md outputs 0.
REQ-019 Load-use hazard SHALL be ex_is_load && ex_rd!=0 && ((id_rs_re && id_rs==ex_rd) || (id_rt_re && id_rt==ex_rd)).
REQ-020 Load-use in RUN: pc_wena=0, ifid_wena=0, idex_bubble=1; all others default. Stall is exactly one cycle per hazard.
REQ-021 branch_taken in RUN without load-use: ifid_flush=1. Load-use has priority, so branch_taken is ignored during the load-use cycle and re-evaluated next cycle.
REQ-022 Start of mult/div: ex_md_start in RUN means N = DIV_CYCLES if ex_md_is_div, else MUL_CYCLES.
REQ-023 In the start cycle: pc_wena=ifid_wena=idex_wena=0, exmem_bubble=1, memwb_wena=1, md_busy=1; next state MD_WAIT with cnt=N-2.
REQ-024 MD_WAIT with cnt!=0: same outputs as REQ-023; cnt decrements.
REQ-025 MD_WAIT with cnt==0 (release): all enables 1, md_done=1, md_busy=0; next state RUN.
REQ-026 In the release cycle, branch_taken SHALL be honoured per REQ-021.
REQ-027 Total stall for a mult/div SHALL be N-1 cycles, and the instruction leaves EX on cycle N.
REQ-028 ex_md_start, branch_taken and the load-use hazard SHALL be ignored while stalled in MD_WAIT.
REQ-029 exc_flush SHALL have highest priority in any state: all enables 1, ifid_flush=1, idex_bubble=1, md_busy=0, md_done=0.
REQ-030 exc_flush SHALL force next state RUN and cnt=0, aborting any mult/div.
REQ-031 stall_cnt SHALL increment by 1 on every cycle in which pc_wena=0, and wraps 0xFFFFFFFF to 0.

Reset
REQ-032 While rst=0 (asynchronous): state=RUN, cnt=0, stall_cnt=0; outputs per REQ-018 evaluated with current inputs.
REQ-033 Reset during MD_WAIT SHALL abort the operation with no md_done pulse.
REQ-034 The first falling edge after rst rises SHALL behave as a normal RUN cycle.

Verification
REQ-035 Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_rs_re=1 -> one cycle with pc_wena=0, idex_bubble=1; stall_cnt=1.
REQ-036 ex_rd=0 load with id_rs=0, id_rs_re=1 -> no stall.
REQ-037 Default divide (32): md_busy high 31 cycles, md_done on cycle 32; stall_cnt +31.
REQ-038 Multiply with MUL_CYCLES=2 -> 1 stall cycle, md_done on cycle 2.
REQ-039 exc_flush at cnt=10 of a divide -> same cycle ifid_flush=1, idex_bubble=1, all enables 1; RUN next; no md_done.
REQ-040 Load-use and branch_taken together -> cycle 1 stall only; cycle 2 ifid_flush=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/exception flushes and
// multi-cycle mult/div EX stalls, all updated on the falling clock edge.
module pipe_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_re,
  input  logic        id_rt_re,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        branch_taken,
  input  logic        exc_flush,
  output logic        pc_wena,
  output logic        ifid_wena,
  output logic        idex_wena,
  output logic        exmem_wena,
  output logic        memwb_wena,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  // The start cycle is itself a stall cycle, so the wait counter loads N-2.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       load_use;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs_re && (id_rs == ex_rd)) ||
                     (id_rt_re && (id_rt == ex_rd)));

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (exc_flush) begin
      state_nxt = RUN;
      cnt_nxt   = 6'd0;
    end else if (state == RUN) begin
      if (ex_md_start) begin
        state_nxt = MD_WAIT;
        cnt_nxt   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
      end
    end else if (cnt != 6'd0) begin
      cnt_nxt = cnt - 6'd1;
    end else begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    pc_wena      = 1'b1;
    ifid_wena    = 1'b1;
    idex_wena    = 1'b1;
    exmem_wena   = 1'b1;
    memwb_wena   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (exc_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state == MD_WAIT && cnt != 6'd0) ||
                 (state == RUN && ex_md_start)) begin
      // Freeze the front end while the mult/div occupies EX; MEM/WB drains.
      pc_wena      = 1'b0;
      ifid_wena    = 1'b0;
      idex_wena    = 1'b0;
      exmem_bubble = 1'b1;
      md_busy      = 1'b1;
    end else if (state == MD_WAIT) begin
      md_done    = 1'b1;
      ifid_flush = branch_taken;
    end else if (load_use) begin
      pc_wena     = 1'b0;
      ifid_wena   = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = branch_taken;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= 32'd0;
    else if (!pc_wena)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: inputs change on the rising edge,
// outputs are checked 1 time unit later, state advances on the falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_rs_re = 0, id_rt_re = 0, ex_is_load = 0;
  logic        ex_md_start = 0, ex_md_is_div = 0, branch_taken = 0, exc_flush = 0;
  logic        pc_wena, ifid_wena, idex_wena, exmem_wena, memwb_wena;
  logic        ifid_flush, idex_bubble, exmem_bubble, md_busy, md_done;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector order: pc,ifid,idex,exmem,memwb enables | ifid_flush,idex_bubble,exmem_bubble,md_busy,md_done
  localparam logic [9:0] O_DEF   = 10'b11111_00000;
  localparam logic [9:0] O_LU    = 10'b00111_01000;
  localparam logic [9:0] O_BR    = 10'b11111_10000;
  localparam logic [9:0] O_MD    = 10'b00011_00110;
  localparam logic [9:0] O_REL   = 10'b11111_00001;
  localparam logic [9:0] O_RELBR = 10'b11111_10001;
  localparam logic [9:0] O_EXC   = 10'b11111_11000;

  wire [9:0] outs = {pc_wena, ifid_wena, idex_wena, exmem_wena, memwb_wena,
                     ifid_flush, idex_bubble, exmem_bubble, md_busy, md_done};

  pipe_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .branch_taken(branch_taken), .exc_flush(exc_flush),
    .pc_wena(pc_wena), .ifid_wena(ifid_wena), .idex_wena(idex_wena),
    .exmem_wena(exmem_wena), .memwb_wena(memwb_wena),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // One pipeline cycle: drive inputs after the rising edge, settle, then check.
  task automatic applyStimulus(input logic ld, input logic [4:0] rd,
                               input logic [4:0] rs, input logic rs_re,
                               input logic [4:0] rt, input logic rt_re,
                               input logic md, input logic div,
                               input logic br, input logic exc);
    @(posedge clk);
    ex_is_load = ld; ex_rd = rd; id_rs = rs; id_rs_re = rs_re;
    id_rt = rt; id_rt_re = rt_re; ex_md_start = md; ex_md_is_div = div;
    branch_taken = br; exc_flush = exc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  initial begin
    // Reset held: RUN-state defaults and a cleared counter
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_outs", 32'(outs), 32'(O_DEF));
    checkOutput("reset_cnt", stall_cnt, 0);
    rst = 1'b1;

    // Load-use on rs
    applyStimulus(1, 5, 5, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_rs", 32'(outs), 32'(O_LU));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_rs_after", 32'(outs), 32'(O_DEF));
    checkOutput("lu_rs_cnt", stall_cnt, 1);

    // r0 destination never stalls
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("lu_r0", 32'(outs), 32'(O_DEF));

    // rt match ignored unless rt is read
    applyStimulus(1, 7, 3, 1, 7, 0, 0, 0, 0, 0);
    checkOutput("lu_rt_noread", 32'(outs), 32'(O_DEF));
    applyStimulus(1, 7, 3, 1, 7, 1, 0, 0, 0, 0);
    checkOutput("lu_rt", 32'(outs), 32'(O_LU));

    // Load-use with branch: stall first, flush next cycle
    applyStimulus(1, 9, 9, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("lu_br_c1", 32'(outs), 32'(O_LU));
    applyStimulus(0, 0, 9, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("lu_br_c2", 32'(outs), 32'(O_BR));
    checkOutput("lu_br_cnt", stall_cnt, 3);

    // Divide: 31 busy cycles ignoring branch/load-use, release on cycle 32
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("div_c1", 32'(outs), 32'(O_MD));
    for (int i = 2; i <= 31; i++) begin
      applyStimulus(1, 4, 4, 1, 0, 0, 1, 1, 1, 0);
      checkOutput($sformatf("div_c%0d", i), 32'(outs), 32'(O_MD));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    checkOutput("div_release", 32'(outs), 32'(O_RELBR));
    checkOutput("div_cnt", stall_cnt, 34);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_after", 32'(outs), 32'(O_DEF));

    // Two-cycle multiply: one stall, done on cycle 2
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mul_c1", 32'(outs), 32'(O_MD));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mul_c2", 32'(outs), 32'(O_REL));
    checkOutput("mul_cnt", stall_cnt, 35);

    // Exception at cnt=10 of a divide (cycle 22) aborts it
    for (int i = 1; i <= 21; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("exc_pre", 32'(outs), 32'(O_MD));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    checkOutput("exc_div", 32'(outs), 32'(O_EXC));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_after", 32'(outs), 32'(O_DEF));
    checkOutput("exc_cnt", stall_cnt, 56);

    // Exception overrides a load-use in RUN
    applyStimulus(1, 5, 5, 1, 0, 0, 0, 0, 1, 1);
    checkOutput("exc_lu", 32'(outs), 32'(O_EXC));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_lu_cnt", stall_cnt, 56);

    // Reset mid-divide: abort with no done pulse
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("rst_md_busy", 32'(outs), 32'(O_MD));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_md_outs", 32'(outs), 32'(O_DEF));
    checkOutput("rst_md_cnt", stall_cnt, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst", 32'(outs), 32'(O_DEF));
    applyStimulus(1, 6, 0, 0, 6, 1, 0, 0, 0, 0);
    checkOutput("post_rst_lu", 32'(outs), 32'(O_LU));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_cnt", stall_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
